hazard_ctrl: RTL and testbench



---
 rtl/pipe_pkg.sv | 23 ++
 rtl/hazard_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: sequencer states, register-zero index and the
// opcode constants the pipeline uses to classify Exec-stage loads.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    function automatic logic is_load_op(input logic [6:0] opcode);
        return opcode == OPC_LOAD;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms: load-use between Exec and Dec, and a data
// memory access that has not completed this cycle.
import pipe_pkg::*;

module hazard_detect (
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic       dec_use_rs1_i,
    input  logic       dec_use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_wen_i,
    input  logic       ex_is_load_i,
    input  logic       dmem_req_i,
    input  logic       dmem_ready_i,
    output logic       load_use_o,
    output logic       mem_busy_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = dec_use_rs1_i && (dec_rs1_i == ex_rd_i);
    assign rs2_hit    = dec_use_rs2_i && (dec_rs2_i == ex_rd_i);
    assign load_use_o = ex_is_load_i && ex_wen_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);
    assign mem_busy_o = dmem_req_i && !dmem_ready_i;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: hazard priority, halt drain, stall-cycle
// counter and sticky data-memory timeout flag.
import pipe_pkg::*;

module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_wen,
    input  logic             ex_is_load,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_if,
    output logic             stall_IF,
    output logic             stall_Dec,
    output logic             stall_all,
    output logic             flush_IF,
    output logic             flush_Dec,
    output logic             halt,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q;
    logic [DW-1:0]    drain_q;
    logic [WW-1:0]    wait_q;
    logic             halt_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             load_use;
    logic             mem_busy;

    hazard_detect u_detect (
        .dec_rs1_i     (dec_rs1),
        .dec_rs2_i     (dec_rs2),
        .dec_use_rs1_i (dec_use_rs1),
        .dec_use_rs2_i (dec_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_wen_i      (ex_wen),
        .ex_is_load_i  (ex_is_load),
        .dmem_req_i    (dmem_req),
        .dmem_ready_i  (dmem_ready),
        .load_use_o    (load_use),
        .mem_busy_o    (mem_busy)
    );

    assign stall_Dec = 1'b0;

    always_comb begin
        stall_IF  = 1'b0;
        stall_all = 1'b0;
        flush_IF  = 1'b0;
        flush_Dec = 1'b0;
        if (state_q == HALTED) begin
            stall_all = 1'b1;
        end else begin
            if (mem_busy) begin
                stall_all = 1'b1;
            end else if (load_use) begin
                stall_IF  = 1'b1;
                flush_Dec = 1'b1;
            end else if (br_taken && state_q == RUN) begin
                flush_IF = 1'b1;
            end
            // Fetch stays frozen for the whole drain, even under a memory stall.
            if (state_q == DRAIN) stall_IF = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            drain_q     <= '0;
            wait_q      <= '0;
            halt_q      <= 1'b0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_if && !mem_busy) begin
                        state_q <= DRAIN;
                        drain_q <= '0;
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                            state_q <= HALTED;
                            halt_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                end
                HALTED: ;
                default: state_q <= RUN;
            endcase

            // Wait counter parks at the limit; the next busy cycle raises the flag.
            if (mem_busy) begin
                if (wait_q < WW'(MEM_TIMEOUT)) wait_q <= wait_q + WW'(1);
                else                           mem_err_q <= 1'b1;
            end else begin
                wait_q <= '0;
            end

            if ((stall_IF || stall_all) && state_q != HALTED && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign halt         = halt_q;
    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hazard priority, memory wait/timeout, halt
// drain and asynchronous reset, plus counter saturation on a narrow instance.
module tb_hazard_ctrl;

    logic        clk;
    logic        rstn;
    logic [4:0]  dec_rs1, dec_rs2, ex_rd;
    logic        dec_use_rs1, dec_use_rs2, ex_wen, ex_is_load;
    logic        br_taken, dmem_req, dmem_ready, halt_if;
    logic        stall_IF, stall_Dec, stall_all, flush_IF, flush_Dec, halt, mem_err;
    logic [31:0] stall_cycles;
    logic        s_stall_IF, s_stall_Dec, s_stall_all, s_flush_IF, s_flush_Dec, s_halt, s_mem_err;
    logic [1:0]  s_stall_cycles;

    int checks;
    int errors;
    int exp_cnt;

    hazard_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_if(halt_if),
        .stall_IF(stall_IF), .stall_Dec(stall_Dec), .stall_all(stall_all),
        .flush_IF(flush_IF), .flush_Dec(flush_Dec), .halt(halt), .mem_err(mem_err),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(2)) u_sat (
        .clk(clk), .rstn(rstn),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_if(halt_if),
        .stall_IF(s_stall_IF), .stall_Dec(s_stall_Dec), .stall_all(s_stall_all),
        .flush_IF(s_flush_IF), .flush_Dec(s_flush_Dec), .halt(s_halt), .mem_err(s_mem_err),
        .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_wen = 1'b0; ex_is_load = 1'b0; br_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; halt_if = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; dec_rs1 = 5'd5; dec_use_rs1 = 1'b1;
    endtask

    // Packs the five combinational controls as {stall_IF, stall_Dec, stall_all, flush_IF, flush_Dec}.
    function automatic logic [4:0] ctl();
        return {stall_IF, stall_Dec, stall_all, flush_IF, flush_Dec};
    endfunction

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        set_idle();
        #12;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL reset_ctl got %b want 00000", ctl()); end
        checks++; if ({halt, mem_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {halt, mem_err}); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
        to_negedge();
        rstn = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        set_idle(); set_load_use(); #1;
        checks++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL lu_rs1_ctl got %b want 10001", ctl()); end
        next_cycle(); exp_cnt++;
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL lu_rs1_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
        set_idle(); #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_release_ctl got %b want 00000", ctl()); end
        next_cycle();
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL lu_release_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
        ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd17; dec_rs1 = 5'd3; dec_use_rs1 = 1'b1;
        dec_rs2 = 5'd17; dec_use_rs2 = 1'b1; #1;
        checks++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL lu_rs2_ctl got %b want 10001", ctl()); end
        next_cycle(); exp_cnt++;
        checks++; if (s_stall_cycles !== 2'd2) begin errors++; $display("FAIL sat_track got %0d want 2", s_stall_cycles); end
        to_negedge();
    endtask

    task automatic test_no_stall();
        set_idle(); ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd0; dec_rs1 = 5'd0; dec_use_rs1 = 1'b1; #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_rd0_ctl got %b want 00000", ctl()); end
        set_idle(); set_load_use(); dec_use_rs1 = 1'b0; #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_nouse_ctl got %b want 00000", ctl()); end
        set_idle(); set_load_use(); ex_wen = 1'b0; #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL lu_nowen_ctl got %b want 00000", ctl()); end
        next_cycle();
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL no_stall_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
    endtask

    task automatic test_branch();
        set_idle(); br_taken = 1'b1; #1;
        checks++; if (ctl() !== 5'b00010) begin errors++; $display("FAIL br_only_ctl got %b want 00010", ctl()); end
        next_cycle();
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL br_only_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
        set_load_use(); #1;
        checks++; if (ctl() !== 5'b10001) begin errors++; $display("FAIL br_lu_ctl got %b want 10001", ctl()); end
        next_cycle(); exp_cnt++;
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL br_lu_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
    endtask

    task automatic test_mem_wait();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                set_idle(); dmem_req = 1'b1; dmem_ready = 1'b0;
                if (pass == 1) begin set_load_use(); br_taken = 1'b1; end
                #1;
                checks++; if (ctl() !== 5'b00100) begin errors++; $display("FAIL mem_wait_ctl pass %0d cyc %0d got %b want 00100", pass, i, ctl()); end
                next_cycle(); exp_cnt++;
                to_negedge();
            end
            set_idle(); dmem_req = 1'b1; dmem_ready = 1'b1; #1;
            checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL mem_ready_ctl pass %0d got %b want 00000", pass, ctl()); end
            next_cycle();
            checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL mem_wait_cnt pass %0d got %0d want %0d", pass, stall_cycles, exp_cnt); end
            checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mem_wait_err pass %0d got %b want 0", pass, mem_err); end
            to_negedge();
        end
        checks++; if (s_stall_cycles !== 2'd3) begin errors++; $display("FAIL sat_hold got %0d want 3", s_stall_cycles); end
    endtask

    task automatic test_timeout();
        for (int i = 1; i <= 6; i++) begin
            set_idle(); dmem_req = 1'b1; dmem_ready = 1'b0; #1;
            checks++; if (stall_all !== 1'b1) begin errors++; $display("FAIL timeout_stall cyc %0d got %b want 1", i, stall_all); end
            next_cycle(); exp_cnt++;
            checks++; if (mem_err !== (i >= 5)) begin errors++; $display("FAIL timeout_err edge %0d got %b want %b", i, mem_err, (i >= 5)); end
            to_negedge();
        end
        set_idle(); dmem_req = 1'b1; dmem_ready = 1'b1;
        next_cycle();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b want 1", mem_err); end
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL timeout_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        to_negedge();
    endtask

    task automatic test_halt();
        set_idle(); halt_if = 1'b1; #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL halt_detect_ctl got %b want 00000", ctl()); end
        next_cycle(); to_negedge();
        for (int i = 0; i < 4; i++) begin
            set_idle(); if (i == 1) br_taken = 1'b1; #1;
            checks++; if (ctl() !== 5'b10000) begin errors++; $display("FAIL drain_ctl cyc %0d got %b want 10000", i, ctl()); end
            checks++; if (halt !== 1'b0) begin errors++; $display("FAIL drain_halt cyc %0d got %b want 0", i, halt); end
            next_cycle(); exp_cnt++;
            to_negedge();
        end
        for (int i = 0; i < 3; i++) begin
            set_idle(); #1;
            checks++; if (ctl() !== 5'b00100 || halt !== 1'b1) begin errors++; $display("FAIL halted_out cyc %0d got ctl %b halt %b want ctl 00100 halt 1", i, ctl(), halt); end
            next_cycle();
            to_negedge();
        end
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL halted_cnt got %0d want %0d", stall_cycles, exp_cnt); end
    endtask

    task automatic test_reset_halted();
        #3 rstn = 1'b0;
        #1;
        checks++; if ({halt, stall_all, mem_err} !== 3'b000) begin errors++; $display("FAIL async_rst_flags got %b want 000", {halt, stall_all, mem_err}); end
        checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL async_rst_cnt got %0d want 0", stall_cycles); end
        to_negedge();
        rstn = 1'b1;
        exp_cnt = 0;
        set_idle(); #1;
        checks++; if (ctl() !== 5'b00000) begin errors++; $display("FAIL post_rst_ctl got %b want 00000", ctl()); end
    endtask

    task automatic test_halt_mem_delay();
        set_idle(); halt_if = 1'b1;
        next_cycle(); to_negedge();
        for (int i = 1; i <= 6; i++) begin
            set_idle();
            if (i == 2 || i == 3) begin dmem_req = 1'b1; dmem_ready = 1'b0; end
            #1;
            checks++; if (stall_IF !== 1'b1 || stall_all !== (i == 2 || i == 3)) begin
                errors++; $display("FAIL drain_mem_ctl cyc %0d got stall_IF %b stall_all %b want 1 %b", i, stall_IF, stall_all, (i == 2 || i == 3)); end
            next_cycle(); exp_cnt++;
            checks++; if (halt !== (i == 6)) begin errors++; $display("FAIL drain_mem_halt edge %0d got %b want %b", i, halt, (i == 6)); end
            to_negedge();
        end
        checks++; if (stall_cycles !== 32'(exp_cnt)) begin errors++; $display("FAIL drain_mem_cnt got %0d want %0d", stall_cycles, exp_cnt); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL drain_mem_err got %b want 0", mem_err); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_cnt = 0;
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_reset_halted();
        test_halt_mem_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
